tlb_mp: RTL and testbench
=========================

TLB_MP -- requirements
Module: tlb_mp

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning TLB entry count (power of two, 4..64); IDX_W = clog2(ENTRIES).
REQ-002 SHALL have parameter PORTS, default 2, meaning number of independent lookup channels (1..4).
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port asid  in  8  current address-space ID.
REQ-006 SHALL have ports lk_req  in  PORTS, and lk_vaddr  in  32*PORTS; these are the per-channel lookup request and virtual address.
REQ-007 SHALL have per-channel outputs, each PORTS wide or 32*PORTS wide as applicable: lk_rvalid, lk_paddr, lk_miss, lk_valid, lk_dirty, lk_uncached.
REQ-008 SHALL have ports wr_en  in  1, wr_random  in  1, wr_index  in  IDX_W, and wr_entry  in  78; these form the entry write port.
REQ-009 SHALL have ports rd_index  in  IDX_W, and rd_entry  out  78; these form the registered entry read port.
REQ-010 SHALL have ports probe_req  in  1, probe_done  out  1, and probe_res  out  32.
REQ-011 SHALL have ports flush_req  in  1, and flush_asid_only  in  1 (sampled together with flush_req).
REQ-012 SHALL have ports busy  out  1 (probe or flush in progress), wired_i  in  IDX_W, and random_o  out  IDX_W.
REQ-013 SHALL use entry layout [77:59] VPN2, [58:51] ASID, [50] G, [49:30] PFN0, [29:27] C0, [26] D0, [25] V0, [24:5] PFN1, [4:2] C1, [1] D1, [0] V1.

Function
REQ-014 SHALL give each lookup channel 1-cycle latency: lk_req at edge N -> lk_rvalid plus result valid after edge N+1; lk_rvalid=0 when lk_req=0, and the result outputs then hold their previous values.
REQ-015 SHALL treat vaddr 0x8000_0000..0xBFFF_FFFF as unmapped: paddr = vaddr & 0x1FFF_FFFF, miss=0, valid=1, dirty=1; uncached = vaddr[29] (kseg1).
REQ-016 SHALL define a mapped hit as VPN2 == vaddr[31:13] and (G or ASID == asid); the even/odd half is selected by vaddr[12]; if several entries hit, the lowest index wins.
REQ-017 SHALL return on mapped hit: paddr = {PFNx[19:0], vaddr[11:0]}, valid=Vx, dirty=Dx, uncached=(Cx==3'd2), miss=0.
REQ-018 SHALL return on mapped miss: miss=1, paddr=0, valid=0, dirty=0, uncached=0.
REQ-019 SHALL write wr_entry into entry[wr_random ? random_o : wr_index] at the edge when wr_en=1 and busy=0; a write SHALL be dropped when busy=1.
REQ-020 SHALL make a lookup in the same cycle as a write see the pre-write table; the write is visible from the next lookup.
REQ-021 SHALL give rd_entry as entry[rd_index] registered with 1-cycle latency, showing pre-write contents on a same-cycle write.
REQ-022 SHALL implement random_o as follows: resets to ENTRIES-1; decrements every cycle; after reaching value wired_i it reloads ENTRIES-1 on the next cycle; if wired_i >= ENTRIES-1 it holds ENTRIES-1.
REQ-023 SHALL use a single FSM with states IDLE, PROBE, FLUSH, DONE; requests are accepted only in IDLE; flush_req has priority over a simultaneous probe_req; requests arriving in other states are ignored.
REQ-024 SHALL perform probe as follows: IDLE->PROBE latches {VPN2,ASID} from wr_entry[77:51]; scans one entry per cycle from index 0 using the REQ-016 match rule (asid taken from the latched value); on first hit or after the last entry -> DONE.
REQ-025 SHALL, in DONE, pulse probe_done=1 for one cycle with probe_res = {miss,23'b0,8'(index)} (index=0 on miss); the FSM then returns to IDLE.
REQ-026 SHALL perform flush as follows: IDLE->FLUSH visits entries 0..ENTRIES-1, one per cycle, clearing V0 and V1 where flush_asid_only=0, or where G=0 and ASID==asid latched at request; after the last entry the FSM goes to IDLE without probe_done.
REQ-027 SHALL, in flush with ENTRIES=16, hold busy=1 for exactly 16 cycles; a probe hit on index k SHALL hold busy=1 for k+2 cycles, covering the scan plus DONE.
REQ-028 SHALL let lookups proceed during busy against the current table, including partially-flushed state.

Reset
REQ-029 SHALL on rst clear all entries to 0, put the FSM in IDLE, set random_o=ENTRIES-1, and drive all other outputs to 0; rst mid-probe/flush SHALL abort without probe_done.

Verification
REQ-030 SHALL cover: write idx3 VPN2=0x00040 ASID=5 PFN1=0x12345 V1=1 D1=0 C1=3, asid=5, lookup 0x00081ABC -> next cycle paddr=0x12345ABC, valid=1, dirty=0, uncached=0, miss=0.
REQ-031 SHALL cover: asid changed to 6 with the same lookup -> miss=1; then rewrite with G=1 -> hit.
REQ-032 SHALL cover: lookup 0xA0001234 -> paddr=0x00001234, uncached=1, miss=0; 0x80001234 -> uncached=0.
REQ-033 SHALL cover: probe VPN2 stored at idx 9 only -> probe_done after 11 cycles, probe_res=0x00000009; absent VPN2 -> probe_res=0x80000000 after 17 cycles.
REQ-034 SHALL cover: wired_i=4 -> random_o sequence 15,14,...,4,15; wr_en during flush is dropped, and the entry is unchanged.
REQ-035 SHALL cover: flush_asid_only=1 with asid=5 over entries {ASID5 G0, ASID5 G1, ASID7} -> only the first has V0=V1=0; rst at flush cycle 3 -> busy=0 and table zeroed.

Source files
------------

// File: rtl/tlb_mp.sv
// rtl/tlb_mp.sv - multi-port joint TLB with write/read ports, random index, probe and flush engine
module tlb_mp #(
    parameter int ENTRIES = 16,
    parameter int PORTS   = 2,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            asid,
    input  logic [PORTS-1:0]      lk_req,
    input  logic [32*PORTS-1:0]   lk_vaddr,
    output logic [PORTS-1:0]      lk_rvalid,
    output logic [32*PORTS-1:0]   lk_paddr,
    output logic [PORTS-1:0]      lk_miss,
    output logic [PORTS-1:0]      lk_valid,
    output logic [PORTS-1:0]      lk_dirty,
    output logic [PORTS-1:0]      lk_uncached,
    input  logic                  wr_en,
    input  logic                  wr_random,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [77:0]           wr_entry,
    input  logic [IDX_W-1:0]      rd_index,
    output logic [77:0]           rd_entry,
    input  logic                  probe_req,
    output logic                  probe_done,
    output logic [31:0]           probe_res,
    input  logic                  flush_req,
    input  logic                  flush_asid_only,
    output logic                  busy,
    input  logic [IDX_W-1:0]      wired_i,
    output logic [IDX_W-1:0]      random_o
);
    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_FLUSH, S_DONE} state_t;

    typedef struct packed {
        logic        miss;
        logic        valid;
        logic        dirty;
        logic        uncached;
        logic [31:0] paddr;
    } lk_res_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    state_t            state_q, state_d;
    logic [77:0]       tbl_q [ENTRIES];
    logic [77:0]       tbl_d [ENTRIES];
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  random_q, random_d;
    logic [26:0]       key_q, key_d;
    logic [7:0]        fasid_q, fasid_d;
    logic              fonly_q, fonly_d;
    logic [31:0]       res_q, res_d;
    logic [77:0]       rd_entry_q, rd_entry_d;
    logic [PORTS-1:0]  rvalid_q, rvalid_d;
    lk_res_t           lk_q [PORTS];
    lk_res_t           lk_d [PORTS];
    logic [31:0]       lk_va;
    logic              lk_hit;
    logic [77:0]       lk_e;
    logic [77:0]       cur;

    assign busy       = (state_q != S_IDLE);
    assign probe_done = (state_q == S_DONE);
    assign probe_res  = res_q;
    assign random_o   = random_q;
    assign rd_entry   = rd_entry_q;
    assign lk_rvalid  = rvalid_q;

    for (genvar p = 0; p < PORTS; p++) begin : g_out
        assign lk_paddr[p*32 +: 32] = lk_q[p].paddr;
        assign lk_miss[p]           = lk_q[p].miss;
        assign lk_valid[p]          = lk_q[p].valid;
        assign lk_dirty[p]          = lk_q[p].dirty;
        assign lk_uncached[p]       = lk_q[p].uncached;
    end

    // Lookups read the registered table, so a same-cycle write is not yet visible.
    always_comb begin
        lk_va    = '0;
        lk_hit   = 1'b0;
        lk_e     = '0;
        rvalid_d = lk_req;
        for (int p = 0; p < PORTS; p++) begin
            lk_d[p] = lk_q[p];
            if (lk_req[p]) begin
                lk_va  = lk_vaddr[p*32 +: 32];
                lk_hit = 1'b0;
                lk_e   = '0;
                for (int i = ENTRIES - 1; i >= 0; i--) begin
                    if (tbl_q[i][77:59] == lk_va[31:13] &&
                        (tbl_q[i][50] || tbl_q[i][58:51] == asid)) begin
                        lk_hit = 1'b1;
                        lk_e   = tbl_q[i];
                    end
                end
                if (lk_va[31:30] == 2'b10) begin
                    lk_d[p].miss     = 1'b0;
                    lk_d[p].valid    = 1'b1;
                    lk_d[p].dirty    = 1'b1;
                    lk_d[p].uncached = lk_va[29];
                    lk_d[p].paddr    = {3'b000, lk_va[28:0]};
                end else if (lk_hit && lk_va[12]) begin
                    lk_d[p].miss     = 1'b0;
                    lk_d[p].valid    = lk_e[0];
                    lk_d[p].dirty    = lk_e[1];
                    lk_d[p].uncached = (lk_e[4:2] == 3'd2);
                    lk_d[p].paddr    = {lk_e[24:5], lk_va[11:0]};
                end else if (lk_hit) begin
                    lk_d[p].miss     = 1'b0;
                    lk_d[p].valid    = lk_e[25];
                    lk_d[p].dirty    = lk_e[26];
                    lk_d[p].uncached = (lk_e[29:27] == 3'd2);
                    lk_d[p].paddr    = {lk_e[49:30], lk_va[11:0]};
                end else begin
                    lk_d[p] = '{miss: 1'b1, valid: 1'b0, dirty: 1'b0, uncached: 1'b0, paddr: 32'h0};
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        key_d      = key_q;
        fasid_d    = fasid_q;
        fonly_d    = fonly_q;
        res_d      = res_q;
        tbl_d      = tbl_q;
        rd_entry_d = tbl_q[rd_index];
        cur        = tbl_q[idx_q];
        // Reload once wired is reached, or if wired moved above the current value.
        if (wired_i >= LAST || random_q <= wired_i) begin
            random_d = LAST;
        end else begin
            random_d = random_q - 1'b1;
        end
        if (wr_en && state_q == S_IDLE) begin
            tbl_d[wr_random ? random_q : wr_index] = wr_entry;
        end
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                    idx_d   = '0;
                    fasid_d = asid;
                    fonly_d = flush_asid_only;
                end else if (probe_req) begin
                    state_d = S_PROBE;
                    idx_d   = '0;
                    key_d   = wr_entry[77:51];
                end
            end
            S_PROBE: begin
                if (cur[77:59] == key_q[26:8] && (cur[50] || cur[58:51] == key_q[7:0])) begin
                    res_d   = {1'b0, 23'b0, 8'(idx_q)};
                    state_d = S_DONE;
                end else if (idx_q == LAST) begin
                    res_d   = 32'h8000_0000;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (!fonly_q || (!cur[50] && cur[58:51] == fasid_q)) begin
                    tbl_d[idx_q][25] = 1'b0;
                    tbl_d[idx_q][0]  = 1'b0;
                end
                if (idx_q == LAST) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            random_q   <= LAST;
            key_q      <= '0;
            fasid_q    <= '0;
            fonly_q    <= 1'b0;
            res_q      <= '0;
            rd_entry_q <= '0;
            rvalid_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
            for (int p = 0; p < PORTS; p++) lk_q[p] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            random_q   <= random_d;
            key_q      <= key_d;
            fasid_q    <= fasid_d;
            fonly_q    <= fonly_d;
            res_q      <= res_d;
            rd_entry_q <= rd_entry_d;
            rvalid_q   <= rvalid_d;
            tbl_q      <= tbl_d;
            lk_q       <= lk_d;
        end
    end
endmodule

// File: tb/tb_tlb_mp.sv
// tb/tb_tlb_mp.sv - scoreboard bench for tlb_mp: lookups, probe, flush, random index, reset
module tb_tlb_mp;
    localparam int ENTRIES = 16;
    localparam int PORTS   = 2;
    localparam int IDX_W   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          asid;
    logic [PORTS-1:0]    lk_req;
    logic [32*PORTS-1:0] lk_vaddr;
    logic [PORTS-1:0]    lk_rvalid, lk_miss, lk_valid, lk_dirty, lk_uncached;
    logic [32*PORTS-1:0] lk_paddr;
    logic                wr_en, wr_random;
    logic [IDX_W-1:0]    wr_index, rd_index, wired_i, random_o;
    logic [77:0]         wr_entry, rd_entry;
    logic                probe_req, probe_done, flush_req, flush_asid_only, busy;
    logic [31:0]         probe_res;

    tlb_mp #(.ENTRIES(ENTRIES), .PORTS(PORTS)) dut (
        .clk(clk), .rst(rst), .asid(asid),
        .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_rvalid(lk_rvalid), .lk_paddr(lk_paddr),
        .lk_miss(lk_miss), .lk_valid(lk_valid), .lk_dirty(lk_dirty), .lk_uncached(lk_uncached),
        .wr_en(wr_en), .wr_random(wr_random), .wr_index(wr_index), .wr_entry(wr_entry),
        .rd_index(rd_index), .rd_entry(rd_entry),
        .probe_req(probe_req), .probe_done(probe_done), .probe_res(probe_res),
        .flush_req(flush_req), .flush_asid_only(flush_asid_only),
        .busy(busy), .wired_i(wired_i), .random_o(random_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] pa;
        logic        m, v, d, u;
        string       nm;
    } lk_exp_t;
    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } pr_exp_t;

    lk_exp_t lkq[$];
    pr_exp_t prq[$];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [77:0] act, input logic [77:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [77:0] mk(input logic [18:0] vpn, input logic [7:0] as, input logic g,
                                       input logic [19:0] p0, input logic [2:0] c0, input logic d0, input logic v0,
                                       input logic [19:0] p1, input logic [2:0] c1, input logic d1, input logic v1);
        return {vpn, as, g, p0, c0, d0, v0, p1, c1, d1, v1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        lk_req    = '0;
        wr_en     = 1'b0;
        wr_random = 1'b0;
        probe_req = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic issue(input int p, input logic [31:0] va, input logic [31:0] pa,
                         input logic m, input logic v, input logic d, input logic u, input string nm);
        lk_exp_t e;
        lk_req[p] = 1'b1;
        lk_vaddr[p*32 +: 32] = va;
        e.port = p; e.pa = pa; e.m = m; e.v = v; e.d = d; e.u = u; e.nm = nm;
        lkq.push_back(e);
    endtask

    task automatic wr(input logic [IDX_W-1:0] idx, input logic [77:0] e);
        wr_en = 1'b1; wr_random = 1'b0; wr_index = idx; wr_entry = e;
        step();
    endtask

    task automatic rd(input logic [IDX_W-1:0] idx, input logic [77:0] exp, input string nm);
        rd_index = idx;
        @(posedge clk);
        #1;
        chk(nm, rd_entry, exp);
    endtask

    task automatic probe(input logic [18:0] vpn, input logic [7:0] as, input logic [31:0] res, input int lat);
        pr_exp_t e;
        int cnt = 0;
        wr_entry  = {vpn, as, 51'b0};
        probe_req = 1'b1;
        e.res = res; e.lat = lat; e.t0 = cyc;
        prq.push_back(e);
        step();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk("probe_busy_cycles", cnt, lat);
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    initial begin
        lk_exp_t e;
        pr_exp_t pe;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int p = 0; p < PORTS; p++) begin
                    if (lk_rvalid[p]) begin
                        if (lkq.size() == 0) begin
                            chk("lk_unexpected", 1, 0);
                        end else begin
                            e = lkq.pop_front();
                            chk({e.nm, "_port"}, p, e.port);
                            chk({e.nm, "_paddr"}, lk_paddr[p*32 +: 32], e.pa);
                            chk({e.nm, "_flags"}, {lk_miss[p], lk_valid[p], lk_dirty[p], lk_uncached[p]},
                                {e.m, e.v, e.d, e.u});
                        end
                    end
                end
                if (probe_done) begin
                    if (prq.size() == 0) begin
                        chk("probe_unexpected", 1, 0);
                    end else begin
                        pe = prq.pop_front();
                        chk("probe_res", probe_res, pe.res);
                        chk("probe_latency", cyc - pe.t0, pe.lat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [77:0] e3, e3g, e7, e0, e1, e2, e15;
        int cnt;
        bit found;
        rst = 1'b1; asid = 8'd5; lk_req = '0; lk_vaddr = '0;
        wr_en = 1'b0; wr_random = 1'b0; wr_index = '0; wr_entry = '0; rd_index = '0;
        probe_req = 1'b0; flush_req = 1'b0; flush_asid_only = 1'b0; wired_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_random", random_o, 15);
        chk("rst_busy", busy, 0);
        chk("rst_probe_done", probe_done, 0);
        chk("rst_rvalid", lk_rvalid, 0);
        chk("rst_paddr", lk_paddr, 0);
        chk("rst_rd_entry", rd_entry, 0);
        rst = 1'b0;

        e3  = mk(19'h00040, 8'd5, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1);
        e3g = mk(19'h00040, 8'd5, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1);
        wr(3, e3);
        issue(0, 32'h00081ABC, 32'h12345ABC, 1'b0, 1'b1, 1'b0, 1'b0, "hit_odd");
        step();
        step();
        chk("lk_hold_paddr", lk_paddr[31:0], 32'h12345ABC);

        asid = 8'd6;
        issue(0, 32'h00081ABC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, "asid_miss");
        step();
        wr_en = 1'b1; wr_index = 3; wr_entry = e3g;
        issue(1, 32'h00081ABC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, "pre_write_miss");
        step();
        issue(1, 32'h00081ABC, 32'h12345ABC, 1'b0, 1'b1, 1'b0, 1'b0, "global_hit");
        step();

        issue(0, 32'hA0001234, 32'h00001234, 1'b0, 1'b1, 1'b1, 1'b1, "kseg1");
        issue(1, 32'h80001234, 32'h00001234, 1'b0, 1'b1, 1'b1, 1'b0, "kseg0");
        step();

        wr(5, mk(19'h00100, 8'd0, 1'b1, 20'h0ABCD, 3'd2, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
        issue(0, 32'h00200567, 32'h0ABCD567, 1'b0, 1'b1, 1'b1, 1'b1, "even_half");
        step();
        wr(1, mk(19'h00100, 8'd0, 1'b1, 20'h00111, 3'd3, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
        issue(0, 32'h00200567, 32'h00111567, 1'b0, 1'b1, 1'b0, 1'b0, "lowest_idx");
        step();
        step();

        rd(3, e3g, "rd_idx3");
        e7 = mk(19'h00007, 8'd1, 1'b0, 20'h77777, 3'd1, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        rd_index = 7; wr_en = 1'b1; wr_index = 7; wr_entry = e7;
        step();
        chk("rd_prewrite", rd_entry, 0);
        step();
        chk("rd_postwrite", rd_entry, e7);

        wr(9, mk(19'h01234, 8'd5, 1'b0, 20'hAAAAA, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
        probe(19'h01234, 8'd5, 32'h00000009, 11);
        probe(19'h07777, 8'd5, 32'h80000000, 17);

        wired_i = 4;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (random_o == 15) begin
                found = 1'b1;
                break;
            end
        end
        chk("rand_sync", found, 1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("rand_seq", random_o, 15 - k);
        end
        @(negedge clk);
        chk("rand_reload", random_o, 15);
        wired_i = 15;
        repeat (2) @(negedge clk);
        chk("rand_hold", random_o, 15);
        @(posedge clk);
        #1;
        e15 = mk(19'h02222, 8'd0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0, 20'hBEEF0, 3'd0, 1'b1, 1'b1);
        wr_en = 1'b1; wr_random = 1'b1; wr_entry = e15; wr_index = 2;
        step();
        issue(1, 32'h04445345, 32'hBEEF0345, 1'b0, 1'b1, 1'b1, 1'b0, "random_slot_hit");
        step();
        rd(15, e15, "rd_random_slot");
        wired_i = 0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        asid = 8'd5;
        e0 = mk(19'h00010, 8'd5, 1'b0, 20'h00010, 3'd0, 1'b1, 1'b1, 20'h00011, 3'd0, 1'b1, 1'b1);
        e1 = mk(19'h00011, 8'd5, 1'b1, 20'h00020, 3'd0, 1'b1, 1'b1, 20'h00021, 3'd0, 1'b1, 1'b1);
        e2 = mk(19'h00012, 8'd7, 1'b0, 20'h00030, 3'd0, 1'b1, 1'b1, 20'h00031, 3'd0, 1'b1, 1'b1);
        wr(0, e0);
        wr(1, e1);
        wr(2, e2);
        flush_asid_only = 1'b1; flush_req = 1'b1;
        step();
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (cnt == 2) begin
                wr_en = 1'b1; wr_random = 1'b0; wr_index = 4;
                wr_entry = mk(19'h00044, 8'd5, 1'b1, 20'h1, 3'd0, 1'b1, 1'b1, 20'h1, 3'd0, 1'b1, 1'b1);
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        chk("flush_busy_cycles", cnt, 16);
        rd(0, e0 & ~78'h2000001, "flush_asid_cleared");
        rd(1, e1, "flush_global_kept");
        rd(2, e2, "flush_other_asid_kept");
        rd(4, 78'h0, "flush_write_dropped");
        issue(0, 32'h000200AB, 32'h000100AB, 1'b0, 1'b0, 1'b1, 1'b0, "flushed_hit_invalid");
        step();
        step();

        flush_asid_only = 1'b0; flush_req = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_flush_busy", busy, 0);
        chk("rst_flush_random", random_o, 15);
        rst = 1'b0;
        rd(0, 78'h0, "rst_tbl0");
        rd(1, 78'h0, "rst_tbl1");
        rd(2, 78'h0, "rst_tbl2");
        repeat (3) step();
        chk("lk_queue_drained", lkq.size(), 0);
        chk("probe_queue_drained", prq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
